seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Multi-cycle unsigned 32x32 -> 64 multiplier (MIPS multu semantics) that sequences one
//  shared 32-bit adder instance (ports a, b, c0, s, cout) through 32 shift-add iterations.
//  Sits beside the ALU in the execute stage and drives the HI/LO register pair.
//  The CPU stalls on busy.
//  The block contains a single adder and a small FSM, and trades latency for area.
// PARAMETERS
//  WIDTH   32  operand width; fixed by the 32-bit adder and must not be overridden
//  CNT_W   6   iteration counter width; must hold the value WIDTH
// PORTS
//  clk     in   1   rising-edge clock
//  rst     in   1   asynchronous, active-high reset
//  start   in   1   request; sampled only in IDLE or DONE
//  mcand   in   32  multiplicand, latched when start is accepted
//  mplier  in   32  multiplier, latched when start is accepted
//  busy    out  1   high while the FSM is in RUN
//  done    out  1   one-cycle pulse; hi/lo hold the final product
//  hi      out  32  product[63:32]
//  lo      out  32  product[31:0]
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0, mcand register=0.
//    Reset takes effect immediately, including mid-operation; the partial product is discarded.
//  Datapath: product register P[63:0] = {hi, lo}; operand register M[31:0].
//    Adder inputs: a=P[63:32]; b = P[0] ? M : 0; c0=0.
//    Iteration update: P <= {cout, s, P[31:1]}, i.e. add, then logical shift right by 1.
//    The adder carry is kept as the new P[63]; no bits are lost.
//  FSM: IDLE, RUN, DONE.
//  - IDLE: on start=1, load M<=mcand and P<={32'h0, mplier}; clear counter; go to RUN.
//  - RUN: one iteration per clock; counter increments.
//    On the edge that performs iteration 32 (counter==31 -> 32), go to DONE.
//    start is ignored in RUN; no queuing.
//  - DONE: done=1 for exactly this cycle; hi/lo valid.
//    If start=1, accept it exactly as in IDLE and go to RUN.
//    Otherwise go to IDLE.
//  Latency: if start is accepted on edge k, done is high between edges k+32 and k+33.
//    The next start is accepted at the earliest on edge k+33.
//  busy = (state==RUN); busy and done are never high together.
//  Result hold: hi/lo keep the product in IDLE until the next accepted start.
//    During RUN, hi/lo show the partial product and must not be consumed.
//  Operand inputs may change freely after start is accepted; M and P are internal copies.
// CONFIGURATION
//  SEQ_MULT_EARLY_TERM_EN defined:
//    In IDLE/DONE, if start=1 and (mcand==0 or mplier==0), load P<=0 and go directly to DONE.
//    done is high between edges k+1 and k+2; the RUN state is skipped.
//  SEQ_MULT_EARLY_TERM_EN undefined:
//    Every operation takes the full 32 iterations, including zero operands.
//    Latency is always 32 cycles.
// TESTING
//  1 Basic: start with mcand=3, mplier=5 -> done exactly 32 cycles after the accepting edge;
//    hi=0, lo=0x0000000F.
//  2 Carry: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (checks that cout is kept).
//  3 Cross-word: 0x80000000 x 2 -> hi=1, lo=0.
//    Then 0x12345678 x 0x9ABCDEF0 -> hi=0x0B00EA4E, lo=0x242D2080.
//  4 Busy handling: start=1 held throughout with first operands 7x9, then operands 2x2 -> result 63.
//    Second op is accepted only in DONE; back-to-back done pulses are 33 cycles apart;
//    start pulses during RUN have no effect.
//  5 Reset mid-op: assert rst at iteration 10 -> busy/done/hi/lo are 0 immediately (async).
//    After release, a new 6x7 gives lo=42.
//  6 Zero operand 0 x 0xDEADBEEF -> hi=lo=0.
//    Done after 1 cycle with SEQ_MULT_EARLY_TERM_EN defined, after 32 cycles without it.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle unsigned 32x32 -> 64 multiplier (multu semantics).
// It steps one shared 32-bit adder through 32 shift-add iterations. The product
// register {hi, lo} holds the result after done and keeps it until the next
// accepted start.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN. When it is defined, a zero
// operand finishes in one cycle and the RUN state is skipped.
//
// Handshake: start is sampled only while busy is low (IDLE or DONE). An
// operation is accepted on the clock edge where start=1 in one of those states.
// done is a one-cycle pulse, and hi/lo are valid during that pulse. busy and
// done are never high together.

module seq_mult_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // Plain ripple/inferred adder with carry in and carry out
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c0};

endmodule

module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_mcand;
  logic [CNT_W-1:0]     r_count;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH-1:0]     w_add_b;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
`ifdef SEQ_MULT_EARLY_TERM_EN
  logic                 w_zero_op;
`endif

  // The multiplicand goes into the add only when the current LSB of P is set
  always_comb begin
    w_add_b = r_prod[0] ? r_mcand : '0;
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  // A zero operand means the product is zero, so the iterations can be skipped
  always_comb begin
    w_zero_op = (mcand == '0) || (mplier == '0);
  end
`endif

  seq_mult_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (r_prod[2*WIDTH-1:WIDTH]),
    .b    (w_add_b),
    .c0   (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Control FSM and datapath registers.
  // Each RUN cycle adds, then shifts right by one. The adder carry becomes the new MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prod  <= '0;
      r_mcand <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= mcand;
            r_count <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
            if (w_zero_op) begin
              r_prod  <= '0;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_prod  <= {{WIDTH{1'b0}}, mplier};
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
`else
            r_prod  <= {{WIDTH{1'b0}}, mplier};
            r_state <= S_RUN;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_prod  <= {w_cout, w_sum, r_prod[WIDTH-1:1]};
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_prod[2*WIDTH-1:WIDTH];
  assign lo   = r_prod[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier.
// The driver issues operations and pushes the expected product and expected
// done cycle into queues. A monitor pops those entries and compares them
// whenever done is seen.

module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          cyc;
  int          checks;
  int          errors;
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] last_prod;

  seq_multiplier u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h expected=0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: plain 64-bit unsigned product
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  // cycles from the accepting edge to the edge that raises done
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (a == 32'h0 || b == 32'h0) return 1;
`endif
    return 32;
  endfunction

  // wait (at negedge) until the DUT can accept, bounded
  task automatic wait_ready();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 64'(busy), 64'h0);
  endtask

  // issue one operation; called at a negedge
  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    exp_q.push_back(ref_mul(a, b));
    exp_cyc_q.push_back(cyc + 1 + ref_lat(a, b));
    @(negedge clk);
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("busy_with_done", 64'(busy), 64'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'h0);
      end else begin
        logic [63:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("product", {hi, lo}, e);
        chk("done_cycle", 64'(cyc), 64'(ec));
        last_prod = e;
      end
    end
  end

  // stimulus
  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    last_prod = '0;
    rst       = 1'b1;
    start     = 1'b0;
    mcand     = 32'h0;
    mplier    = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    do_op(32'd3, 32'd5);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'd2);
    do_op(32'h1234_5678, 32'h9ABC_DEF0);
    drain();
    chk("known_vec", last_prod, 64'h0B00_EA4E_242D_2080);

    // result hold in IDLE
    repeat (4) @(negedge clk);
    chk("idle_hold", {hi, lo}, last_prod);

    // start held high throughout: second op accepted only in DONE
    wait_ready();
    start  = 1'b1;
    mcand  = 32'd7;
    mplier = 32'd9;
    n      = cyc;
    exp_q.push_back(64'd63);
    exp_cyc_q.push_back(n + 33);
    @(negedge clk);
    mcand  = 32'd2;
    mplier = 32'd2;
    exp_q.push_back(64'd4);
    exp_cyc_q.push_back(n + 66);
    while (cyc < n + 34) @(negedge clk);
    start = 1'b0;
    drain();

    // start pulses during RUN are ignored
    do_op(32'd11, 32'd13);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd100;
    mplier = 32'd100;
    @(negedge clk);
    start = 1'b0;
    drain();

    // async reset mid-operation
    do_op(32'hABCD_1234, 32'h5678_9ABC);
    n = cyc;
    while (cyc < n + 9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd6, 32'd7);
    drain();
    chk("after_rst_lo", last_prod, 64'd42);

    // zero operands
    do_op(32'h0, 32'hDEAD_BEEF);
    do_op(32'h1234_0000, 32'h0);
    drain();

    // randomized operations, occasionally zero or all-ones
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h0;
        1: b = 32'h0;
        2: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(a, b);
    end
    drain();

    repeat (3) @(negedge clk);
    chk("final_hold", {hi, lo}, last_prod);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
